// File: rtl/minimac2_rxsched.sv
// Receive-slot scheduler for the two MAC receive slots: arms slots, orders completions
// into a single frame stream, and raises a coalesced receive interrupt.
module minimac2_rxsched #(
    parameter int unsigned holdoff_w = 16
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic                 enable,
    input  logic [holdoff_w-1:0] irq_holdoff,
    input  logic [1:0]           rx_done,
    input  logic [10:0]          rx_count_0,
    input  logic [10:0]          rx_count_1,
    output logic [1:0]           rx_ready,
    output logic                 frm_valid,
    output logic                 frm_slot,
    output logic [10:0]          frm_count,
    input  logic                 frm_ack,
    output logic                 irq,
    output logic                 err_spurious,
    output logic [15:0]          stat_frames
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_FULL
    } slot_state_t;

    slot_state_t          state_q [2];
    slot_state_t          state_d [2];
    logic [10:0]          count_q [2];
    logic [10:0]          count_in [2];
    logic                 qe_q [2];
    logic                 qe_d [2];
    logic [1:0]           occ_q, occ_d;
    logic [holdoff_w-1:0] timer_q, timer_d;
    logic                 irq_q, irq_d;
    logic                 err_q, err_d;
    logic [15:0]          frames_q, frames_d;

    logic [1:0]           push;
    logic                 pop;
    logic                 head;

    assign count_in[0] = rx_count_0;
    assign count_in[1] = rx_count_1;

    // State register
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int unsigned i = 0; i < 2; i++) begin
                state_q[i] <= S_IDLE;
                count_q[i] <= '0;
                qe_q[i]    <= 1'b0;
            end
            occ_q    <= '0;
            timer_q  <= '0;
            irq_q    <= 1'b0;
            err_q    <= 1'b0;
            frames_q <= '0;
        end else begin
            for (int unsigned i = 0; i < 2; i++) begin
                state_q[i] <= state_d[i];
                qe_q[i]    <= qe_d[i];
                if (push[i]) begin
                    count_q[i] <= count_in[i];
                end
            end
            occ_q    <= occ_d;
            timer_q  <= timer_d;
            irq_q    <= irq_d;
            err_q    <= err_d;
            frames_q <= frames_d;
        end
    end

    // Next-state logic
    always_comb begin
        head = qe_q[0];
        pop  = frm_ack && (occ_q != 2'd0);
        push = '0;
        err_d = err_q;
        for (int unsigned i = 0; i < 2; i++) begin
            push[i]    = rx_done[i] && (state_q[i] == S_ARMED);
            state_d[i] = state_q[i];
            if (rx_done[i] && (state_q[i] != S_ARMED)) begin
                err_d = 1'b1;
            end
            case (state_q[i])
                S_IDLE:  if (enable) state_d[i] = S_ARMED;
                S_ARMED: if (rx_done[i]) state_d[i] = S_FULL;
                S_FULL:  if (pop && (head == 1'(i))) state_d[i] = enable ? S_ARMED : S_IDLE;
                default: state_d[i] = S_IDLE;
            endcase
        end

        // Pop shifts the tail forward first so pushes land behind the survivor;
        // slot 0 is appended before slot 1 when both complete together.
        qe_d[0] = qe_q[0];
        qe_d[1] = qe_q[1];
        occ_d   = occ_q;
        if (pop) begin
            qe_d[0] = qe_q[1];
            occ_d   = occ_q - 2'd1;
        end
        for (int unsigned i = 0; i < 2; i++) begin
            if (push[i]) begin
                qe_d[occ_d[0]] = 1'(i);
                occ_d          = occ_d + 2'd1;
            end
        end

        frames_d = frames_q + {15'd0, push[0]} + {15'd0, push[1]};

        if (occ_q == 2'd0) begin
            timer_d = '0;
        end else if (timer_q != '1) begin
            timer_d = timer_q + 1'b1;
        end else begin
            timer_d = timer_q;
        end

        irq_d = (occ_q != 2'd0) && ((occ_q == 2'd2) || (timer_q >= irq_holdoff));
    end

    // Outputs
    always_comb begin
        for (int unsigned i = 0; i < 2; i++) begin
            rx_ready[i] = (state_q[i] == S_ARMED);
        end
        frm_valid    = (occ_q != 2'd0);
        frm_slot     = frm_valid ? qe_q[0] : 1'b0;
        frm_count    = frm_valid ? count_q[qe_q[0]] : '0;
        irq          = irq_q;
        err_spurious = err_q;
        stat_frames  = frames_q;
    end

endmodule

// File: tb/tb_minimac2_rxsched.sv
// Directed and randomized bench for minimac2_rxsched against a queue-based reference model.
module tb_minimac2_rxsched;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic        enable;
    logic [15:0] irq_holdoff;
    logic [1:0]  rx_done;
    logic [10:0] rx_count_0;
    logic [10:0] rx_count_1;
    logic [1:0]  rx_ready;
    logic        frm_valid;
    logic        frm_slot;
    logic [10:0] frm_count;
    logic        frm_ack;
    logic        irq;
    logic        err_spurious;
    logic [15:0] stat_frames;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: 0 = idle, 1 = armed, 2 = full
    int m_st [2];
    int m_cnt [2];
    int m_q [$];
    int m_frames;
    int m_timer;
    bit m_irq;
    bit m_err;

    minimac2_rxsched #(.holdoff_w(16)) dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .enable      (enable),
        .irq_holdoff (irq_holdoff),
        .rx_done     (rx_done),
        .rx_count_0  (rx_count_0),
        .rx_count_1  (rx_count_1),
        .rx_ready    (rx_ready),
        .frm_valid   (frm_valid),
        .frm_slot    (frm_slot),
        .frm_count   (frm_count),
        .frm_ack     (frm_ack),
        .irq         (irq),
        .err_spurious(err_spurious),
        .stat_frames (stat_frames)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_st[0] = 0; m_st[1] = 0;
        m_cnt[0] = 0; m_cnt[1] = 0;
        m_q.delete();
        m_frames = 0;
        m_timer = 0;
        m_irq = 0;
        m_err = 0;
    endtask

    task automatic model_step();
        bit pop_ok;
        int hd;
        bit irq_n;
        pop_ok = frm_ack && (m_q.size() > 0);
        hd = pop_ok ? m_q[0] : -1;
        irq_n = (m_q.size() > 0) && ((m_q.size() == 2) || (m_timer >= int'(irq_holdoff)));
        if (m_q.size() == 0) m_timer = 0;
        else if (m_timer < 65535) m_timer = m_timer + 1;
        if (pop_ok) void'(m_q.pop_front());
        for (int i = 0; i < 2; i++) begin
            if (rx_done[i] && m_st[i] != 1) m_err = 1;
            case (m_st[i])
                0: if (enable) m_st[i] = 1;
                1: if (rx_done[i]) begin
                       m_st[i] = 2;
                       m_cnt[i] = (i == 0) ? int'(rx_count_0) : int'(rx_count_1);
                       m_frames = (m_frames + 1) % 65536;
                       m_q.push_back(i);
                   end
                default: if (hd == i) m_st[i] = enable ? 1 : 0;
            endcase
        end
        m_irq = irq_n;
    endtask

    task automatic check_all();
        logic [1:0] exp_rdy;
        exp_rdy[0] = (m_st[0] == 1);
        exp_rdy[1] = (m_st[1] == 1);
        chk("rx_ready", 32'(rx_ready), 32'(exp_rdy));
        chk("frm_valid", 32'(frm_valid), 32'(m_q.size() > 0));
        if (m_q.size() > 0) begin
            chk("frm_slot", 32'(frm_slot), 32'(m_q[0]));
            chk("frm_count", 32'(frm_count), 32'(m_cnt[m_q[0]]));
        end
        chk("irq", 32'(irq), 32'(m_irq));
        chk("err_spurious", 32'(err_spurious), 32'(m_err));
        chk("stat_frames", 32'(stat_frames), 32'(m_frames));
    endtask

    // Called just after a negedge; returns just after the following negedge.
    task automatic step(input logic en, input logic [1:0] done, input logic [10:0] c0,
                        input logic [10:0] c1, input logic a);
        enable = en; rx_done = done; rx_count_0 = c0; rx_count_1 = c1; frm_ack = a;
        @(posedge sys_clk);
        model_step();
        #1;
        check_all();
        @(negedge sys_clk);
    endtask

    task automatic do_reset();
        sys_rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        chk("rst_frm_slot", 32'(frm_slot), 32'd0);
        chk("rst_frm_count", 32'(frm_count), 32'd0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
    endtask

    initial begin
        int k;
        logic [1:0] d;
        sys_rst_n = 1'b1;
        enable = 1'b1; irq_holdoff = 16'd0; rx_done = 2'b00; frm_ack = 1'b0;
        rx_count_0 = '0; rx_count_1 = '0;
        #1;
        do_reset();

        // Arm, then slot 1 completes
        step(1, 2'b00, 0, 0, 0);
        chk("arm_after_reset", 32'(rx_ready), 32'h3);
        step(1, 2'b10, 0, 11'd64, 0);
        chk("s1_slot", 32'(frm_slot), 32'd1);
        chk("s1_count", 32'(frm_count), 32'd64);
        chk("s1_ready", 32'(rx_ready), 32'h1);
        step(1, 2'b00, 0, 0, 1);

        // Simultaneous completion, ordered drain
        step(1, 2'b11, 11'd100, 11'd1514, 0);
        chk("dual_head_slot", 32'(frm_slot), 32'd0);
        chk("dual_head_count", 32'(frm_count), 32'd100);
        step(1, 2'b00, 0, 0, 1);
        chk("ack0_slot", 32'(frm_slot), 32'd1);
        chk("ack0_count", 32'(frm_count), 32'd1514);
        chk("ack0_ready", 32'(rx_ready), 32'h1);
        step(1, 2'b00, 0, 0, 1);
        chk("ack1_valid", 32'(frm_valid), 32'd0);
        chk("ack1_ready", 32'(rx_ready), 32'h3);

        // Holdoff with a single frame
        irq_holdoff = 16'd10;
        step(1, 2'b01, 11'd300, 0, 0);
        chk("ho_valid", 32'(frm_valid), 32'd1);
        k = 0;
        while (irq !== 1'b1 && k < 40) begin
            step(1, 2'b00, 0, 0, 0);
            k++;
        end
        chk("ho_latency", 32'(k), 32'd11);
        step(1, 2'b00, 0, 0, 1);
        step(1, 2'b00, 0, 0, 0);
        chk("irq_fall", 32'(irq), 32'd0);

        // Second frame forces the interrupt through occupancy
        step(1, 2'b01, 11'd77, 0, 0);
        step(1, 2'b00, 0, 0, 0);
        step(1, 2'b00, 0, 0, 0);
        step(1, 2'b10, 0, 11'd5, 0);
        chk("occ2_irq_c3", 32'(irq), 32'd0);
        step(1, 2'b00, 0, 0, 0);
        chk("occ2_irq_c4", 32'(irq), 32'd1);

        // Enable low blocks re-arming after ack
        step(0, 2'b00, 0, 0, 1);
        chk("noarm_ack", 32'(rx_ready[0]), 32'd0);
        step(0, 2'b00, 0, 0, 0);
        chk("noarm_hold", 32'(rx_ready[0]), 32'd0);
        step(1, 2'b00, 0, 0, 0);
        chk("arm_on_enable", 32'(rx_ready[0]), 32'd1);

        // Spurious completion on a full slot
        k = int'(stat_frames);
        step(1, 2'b10, 0, 11'd999, 0);
        chk("spur_err", 32'(err_spurious), 32'd1);
        chk("spur_frames", 32'(stat_frames), 32'(k));
        step(1, 2'b00, 0, 0, 0);
        chk("spur_sticky", 32'(err_spurious), 32'd1);

        // Both full with irq high, then asynchronous reset
        irq_holdoff = 16'd1000;
        step(1, 2'b01, 11'd42, 0, 0);
        step(1, 2'b00, 0, 0, 0);
        chk("pre_reset_irq", 32'(irq), 32'd1);
        #2;
        do_reset();
        chk("post_reset_err", 32'(err_spurious), 32'd0);
        step(1, 2'b01, 11'd8, 0, 0);
        chk("release_spur", 32'(err_spurious), 32'd1);
        chk("release_nopush", 32'(frm_valid), 32'd0);

        // Randomized phase
        do_reset();
        for (int n = 0; n < 400; n++) begin
            if (n % 50 == 0) irq_holdoff = 16'($urandom_range(0, 15));
            for (int i = 0; i < 2; i++) begin
                if (m_st[i] == 1) d[i] = ($urandom_range(0, 2) == 0);
                else d[i] = ($urandom_range(0, 39) == 0);
            end
            step($urandom_range(0, 7) != 0, d, 11'($urandom), 11'($urandom),
                 $urandom_range(0, 2) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/minimac2_rxsched.md
Name: minimac2_rxsched

Overview:
- Sys-clock scheduler for the two MAC receive slots.
- Arms each slot towards the clock-domain synchronizer via rx_ready.
- Captures slot completions in arrival order and presents them to the consumer (CSR/DMA logic) as one ordered frame stream with a valid/ack handshake.
- Generates a coalesced receive interrupt with a programmable holdoff, replacing per-slot software polling.

Parameters:
- holdoff_w, 16, width of irq_holdoff and of the internal holdoff timer.

Ports:
- sys_clk  in  1  system clock
- sys_rst_n  in  1  asynchronous active-low reset
- enable  in  1  permits arming of free slots
- irq_holdoff  in  holdoff_w  coalescing delay in sys_clk cycles; 0 = immediate
- rx_done  in  2  per-slot single-cycle completion pulse from the synchronizer
- rx_count_0  in  11  byte count of slot 0; valid in the cycle rx_done[0] pulses
- rx_count_1  in  11  byte count of slot 1; valid in the cycle rx_done[1] pulses
- rx_ready  out  2  per-slot armed level towards the synchronizer
- frm_valid  out  1  ordered queue non-empty
- frm_slot  out  1  slot index at queue head
- frm_count  out  11  byte count at queue head
- frm_ack  in  1  consumer releases head slot
- irq  out  1  coalesced receive interrupt, level
- err_spurious  out  1  sticky: rx_done seen for a non-armed slot
- stat_frames  out  16  accepted-frame counter, wraps

Behaviour:
- Reset (asynchronous, sys_rst_n low):
  - Both slots IDLE, queue empty, timer 0.
  - rx_ready=00, frm_valid=0, frm_slot=0, frm_count=0, irq=0, err_spurious=0, stat_frames=0.
- Per-slot state machine, states IDLE, ARMED, FULL:
  - IDLE -> ARMED on a clock edge with enable=1.
  - ARMED -> FULL on rx_done[i]=1. Latch rx_count_i into the slot's count register, push i at queue tail, increment stat_frames.
  - FULL -> ARMED on frm_ack with frm_valid=1 and i at queue head, if enable=1. Otherwise FULL -> IDLE.
  - rx_ready[i]=1 exactly when slot i is ARMED; it is a registered output.
- enable=0 only prevents arming. ARMED slots stay armed and may still complete. No disarm path exists, so there is no race with the rx side.
- rx_done[i] while slot i is IDLE or FULL: pulse ignored, no push, err_spurious set until reset.
- Ordered queue:
  - 2 entries holding slot indices; the count of each entry is read from that slot's register.
  - Overflow is impossible by construction.
  - frm_valid = queue non-empty; frm_slot and frm_count come from the head, combinationally from registers.
- Simultaneous events:
  - rx_done=11 in one cycle: push slot 0 then slot 1; stat_frames +2.
  - Push and pop in the same cycle: both performed, occupancy unchanged.
  - frm_ack with frm_valid=0: ignored.
  - Ack of a slot in the same cycle as rx_done for the other slot: both processed.
- Ack to re-arm latency: rx_ready[i] rises in the cycle after the frm_ack cycle (given enable=1).
- Holdoff timer:
  - Cleared to 0 while the queue is empty.
  - Increments by 1 per cycle while the queue is non-empty; saturates at all-ones.
  - Not restarted by a second push.
- irq, registered, takes the value of this condition one cycle later: frm_valid and (occupancy==2 or timer>=irq_holdoff).
  - irq_holdoff=0: irq rises the cycle after frm_valid rises.
  - irq falls the cycle after the queue empties.
- Reset mid-frame:
  - All slots return to IDLE and rx_ready drops asynchronously.
  - A rx_done arriving after reset release is treated as spurious (err_spurious set).
- Arithmetic:
  - stat_frames wraps modulo 2^16.
  - timer compare is unsigned, holdoff_w bits.

Test Plan:
- Reset release with enable=1 -> rx_ready=11 one cycle later. rx_done[1] with rx_count_1=64 -> frm_valid=1, frm_slot=1, frm_count=64, rx_ready=01, stat_frames=1.
- rx_done=11 in one cycle, rx_count_0=100, rx_count_1=1514 -> head is slot 0/100. Ack -> head is slot 1/1514 and rx_ready=01 next cycle. Ack -> frm_valid=0, rx_ready=11.
- irq_holdoff=10, one frame received -> irq rises exactly 11 cycles after frm_valid rises. Second frame arriving at cycle 3 -> irq rises at cycle 4 (occupancy 2).
- enable=0 while slot 0 FULL; ack slot 0 -> rx_ready[0] stays 0. Raise enable -> rx_ready[0]=1 one cycle later.
- rx_done[0] while slot 0 FULL -> no push, stat_frames unchanged, err_spurious=1 until reset.
- sys_rst_n asserted with both slots FULL and irq=1 -> immediately rx_ready=00, frm_valid=0, irq=0, stat_frames=0.
